mdu_ctrl: RTL

Sequencing controller for the multiply/divide unit and the architectural HI/LO registers of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo commands from the E stage and models multi-cycle latency with a busy counter. It returns HI/LO for mfhi/mflo and drives the D-stage stall request for any HI/LO-related instruction while an operation is in flight.

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_arith.sv | 44 ++++
 rtl/mdu_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and defaults for the multiply/divide controller
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   localparam int MDU_MULT_CYCLES_DEF = 5;
   localparam int MDU_DIV_CYCLES_DEF  = 10;

   localparam logic RD_LO = 1'b0;
   localparam logic RD_HI = 1'b1;

   typedef enum logic {ST_IDLE, ST_BUSY} mdu_state_t;

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational mult/multu/div/divu datapath producing HI/LO results
// Divide works on magnitudes and restores signs, which yields truncation toward zero.
module mdu_arith #(
   parameter int WIDTH = 32
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res,
   output logic             div_zero
);

   logic                 sgn, neg_a, neg_b;
   logic [2*WIDTH-1:0]   ext_a, ext_b, prod;
   logic [WIDTH-1:0]     mag_a, mag_b, dvsr, quo, rem;

   always_comb begin
      // op[0]==0 selects the signed flavour (mult, div)
      sgn      = ~op[0];
      neg_a    = sgn & a[WIDTH-1];
      neg_b    = sgn & b[WIDTH-1];
      ext_a    = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      ext_b    = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
      prod     = ext_a * ext_b;
      mag_a    = neg_a ? -a : a;
      mag_b    = neg_b ? -b : b;
      div_zero = op[1] & (b == '0);
      // substitute divisor keeps the result defined; the commit is suppressed anyway
      dvsr     = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
      quo      = mag_a / dvsr;
      rem      = mag_a % dvsr;
      if (neg_a ^ neg_b) quo = -quo;
      if (neg_a)         rem = -rem;
      if (op[1]) begin
         hi_res = rem;
         lo_res = quo;
      end else begin
         hi_res = prod[2*WIDTH-1:WIDTH];
         lo_res = prod[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - HI/LO registers, busy counter, commit and D-stage stall for the MDU
// Optional exception-flush input enabled by defining MDU_CANCEL_EN.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             rd_sel,
   input  logic             md_in_d,
`ifdef MDU_CANCEL_EN
   input  logic             cancel,
`endif
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   mdu_state_t       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
   logic             commit_ok_q, commit_ok_d;
   logic [WIDTH-1:0] hi_res, lo_res;
   logic             div_zero, flush, accept;

`ifdef MDU_CANCEL_EN
   assign flush = cancel;
`else
   assign flush = 1'b0;
`endif

   mdu_arith #(.WIDTH(WIDTH)) u_arith (
      .op       (op[1:0]),
      .a        (rs_data),
      .b        (rt_data),
      .hi_res   (hi_res),
      .lo_res   (lo_res),
      .div_zero (div_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         hi_tmp_q    <= '0;
         lo_tmp_q    <= '0;
         commit_ok_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         hi_tmp_q    <= hi_tmp_d;
         lo_tmp_q    <= lo_tmp_d;
         commit_ok_q <= commit_ok_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      hi_tmp_d    = hi_tmp_q;
      lo_tmp_d    = lo_tmp_q;
      commit_ok_d = commit_ok_q;
      accept      = start & (state_q == ST_IDLE) & ~flush;
      if (flush) begin
         state_d     = ST_IDLE;
         count_d     = '0;
         commit_ok_d = 1'b0;
      end else if (state_q == ST_BUSY) begin
         count_d = count_q - CW'(1);
         if (count_q == CW'(1)) begin
            state_d     = ST_IDLE;
            commit_ok_d = 1'b0;
            if (commit_ok_q) begin
               hi_d = hi_tmp_q;
               lo_d = lo_tmp_q;
            end
         end
      end else if (accept) begin
         case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
               hi_tmp_d    = hi_res;
               lo_tmp_d    = lo_res;
               commit_ok_d = ~div_zero;
               count_d     = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               state_d     = ST_BUSY;
            end
            MDU_MTHI: hi_d = rs_data;
            MDU_MTLO: lo_d = rs_data;
            default: ;
         endcase
      end
   end

   assign busy    = (state_q == ST_BUSY);
   assign stall   = md_in_d & (start | busy);
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign rd_data = (rd_sel == RD_HI) ? hi_q : lo_q;

   // the D-stage stall must keep new commands away while an operation is in flight
   a_no_start_busy: assert property (@(posedge clk) disable iff (reset || flush) !(start && busy));

endmodule
